muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle integer multiply/divide unit for MULT, MULTU, DIV and DIVU.
//  Sits in EX beside the ALU. It is the write-side producer for the HI/LO register pair:
//  on completion it drives whi/wlo/whilo for one cycle, then HI/LO latch the result.
//  Uses a start/busy/done handshake with the pipeline; the pipeline stalls while busy=1.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo result halves are each WIDTH bits
// PORTS
//  clk     in   1      single clock, rising edge
//  reset   in   1      asynchronous, active-high; clears all state
//  start   in   1      launch op; accepted only when busy=0
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a   in   WIDTH  rs operand (multiplicand / dividend)
//  src_b   in   WIDTH  rt operand (multiplier / divisor)
//  cancel  in   1      flush (exception/eret); aborts the op in flight
//  busy    out  1      high in MUL, DIV and DONE states
//  done    out  1      one-cycle completion pulse
//  whi     out  WIDTH  HI write data (product[63:32] / remainder)
//  wlo     out  WIDTH  LO write data (product[31:0] / quotient)
//  whilo   out  2      2'b11 while done=1, else 2'b00
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, whilo=00, whi=wlo=0; operand and acc regs cleared.
//  - FSM: IDLE -start&!cancel-> MUL|DIV; MUL|DIV -(cnt==WIDTH-1)-> DONE; DONE -> IDLE.
//  - Operands and op are latched on the accepting edge. Later src_a/src_b changes have no effect.
//  - start while busy=1 is ignored. No queueing.
//  - Signed ops work on magnitudes. Product sign = a[31]^b[31].
//    Quotient sign = a[31]^b[31]; remainder sign = a[31]. Fix-up is applied entering DONE.
//  - MUL: radix-2 shift-add, one bit per cycle, 32 iterations, 64-bit accumulator.
//  - DIV: radix-2 restoring, one quotient bit per cycle, 32 iterations.
//  - Latency: start sampled at edge N -> done=1 during cycle N+33 (32 iterations + DONE).
//  - done, whi, wlo and whilo are valid only in DONE; whi=wlo=0 in all other states.
//  - Divide by zero (any sign): no trap; whi=src_a, wlo=32'hFFFFFFFF, same latency.
//  - DIV 0x80000000 / 0xFFFFFFFF: wlo=0x80000000, whi=0; no exception.
//  - cancel=1 in any state: next state is IDLE.
//    In DONE, cancel combinationally forces done=0 and whilo=00, so HI/LO is not written.
//  - cancel and start in the same cycle: cancel wins; the op is not accepted.
//  - reset mid-op: immediate return to IDLE; no done pulse.
//  - Iteration counter is 5 bits and must not wrap past 31 in MUL/DIV.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    MULT/MULTU use a single-cycle combinational 32x32 multiply.
//    IDLE -> DONE directly; done during cycle N+1. DIV is unchanged at 33 cycles.
//  MULDIV_FAST_MUL_EN undefined:
//    Iterative shift-add path as above; done at N+33. No hardware multiplier is inferred.
// STRUCTURE
//  Shared package muldiv_pkg holds:
//    op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU (2 bits);
//    FSM state encodings S_IDLE/S_MUL/S_DIV/S_DONE;
//    WHILO_NONE=2'b00 and WHILO_BOTH=2'b11.
//  Sub-module muldiv_div_core holds the restoring-divide datapath:
//    remainder/quotient shift regs and trial subtract, with load/step/rem/quo ports.
//  The top level keeps the FSM, counter, multiplier, sign fix-up and output muxing.
// TESTING
//  1 MULT a=0xFFFFFFFE(-2), b=3 -> done at N+33: whi=0xFFFFFFFF, wlo=0xFFFFFFFA, whilo=11.
//  2 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> whi=0xFFFFFFFE, wlo=0x00000001.
//  3 DIV a=-7, b=2 -> wlo=0xFFFFFFFD(-3), whi=0xFFFFFFFF(-1).
//    DIVU a=7, b=0 -> whi=7, wlo=0xFFFFFFFF.
//  4 DIV a=0x80000000, b=0xFFFFFFFF -> wlo=0x80000000, whi=0.
//    Second start while busy -> ignored; exactly one done pulse.
//  5 cancel at cycle N+10 of a DIV -> busy=0 next cycle, no done, whilo stays 00.
//    cancel+start in the same cycle -> busy stays 0.
//  6 reset asserted mid-MUL -> all outputs 0 immediately.
//    Rebuild with MULDIV_FAST_MUL_EN: MULTU 3*5 -> done at N+1, wlo=15, whi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, HI/LO write enables.
package muldiv_pkg;

   // Operation encodings as presented on the op input.
   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   // HI/LO write-enable patterns.
   localparam logic [1:0] WHILO_NONE = 2'b00;
   localparam logic [1:0] WHILO_BOTH = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Signed variants have op[0] clear.
   function automatic logic is_signed_op(input logic [1:0] op);
      return !op[0];
   endfunction

   // Divides have op[1] set.
   function automatic logic is_div_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider datapath: unsigned magnitudes in, one quotient bit per step.
module muldiv_div_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem,
   output logic [WIDTH-1:0] quo
);

   logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] sub;
   logic             fits;

   // Trial subtract of the divisor from the partial remainder with the next dividend bit shifted in.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, dvs_q});
      // When the divisor fits the true difference is below 2^WIDTH, so the low bits are exact.
      sub     = shifted[WIDTH-1:0] - dvs_q;
   end

   // Remainder/quotient shift registers; quotient reg doubles as the dividend shifter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         rem_q <= '0;
         quo_q <= dividend;
         dvs_q <= divisor;
      end else if (step) begin
         if (fits) begin
            rem_q <= sub;
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign rem = rem_q;
   assign quo = quo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO write data with a start/busy/done handshake.
// Build option MULDIV_FAST_MUL_EN: multiplies complete in one cycle through a combinational multiplier.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] whi,
   output logic [WIDTH-1:0] wlo,
   output logic [1:0]       whilo
);

   localparam int unsigned    CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [1:0]           op_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 accept, div_load, div_step;
   logic [WIDTH-1:0]     mag_src_a, mag_src_b, mag_a_q;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH-1:0]     div_rem, div_quo;
   logic                 res_neg, rem_neg;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // Operand magnitudes: signed ops run on absolute values, sign restored in DONE.
   always_comb begin
      mag_src_a = (is_signed_op(op) && src_a[WIDTH-1]) ? -src_a : src_a;
      mag_src_b = (is_signed_op(op) && src_b[WIDTH-1]) ? -src_b : src_b;
      mag_a_q   = (is_signed_op(op_q) && a_q[WIDTH-1]) ? -a_q : a_q;
      // Shift-add: low half of acc holds the remaining multiplier bits.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
   end

   // Next-state, iteration counter and accumulator update.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      accept   = 1'b0;
      div_load = 1'b0;
      div_step = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start && !cancel) begin
               accept   = 1'b1;
               div_load = 1'b1;
               cnt_d    = '0;
               if (is_div_op(op)) begin
                  state_d = S_DIV;
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  acc_d   = {{WIDTH{1'b0}}, mag_src_a} * {{WIDTH{1'b0}}, mag_src_b};
                  state_d = S_DONE;
`else
                  acc_d   = {{WIDTH{1'b0}}, mag_src_b};
                  state_d = S_MUL;
`endif
               end
            end
         end
         S_MUL: begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DIV: begin
            div_step = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Flush overrides everything, including a same-cycle start.
      if (cancel) begin
         state_d = S_IDLE;
      end
   end

   // State, counter, accumulator and latched operands.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         op_q    <= MD_MULT;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (accept) begin
            op_q <= op;
            a_q  <= src_a;
            b_q  <= src_b;
         end
      end
   end

   muldiv_div_core #(
      .WIDTH(WIDTH)
   ) u_div_core (
      .clk      (clk),
      .reset    (reset),
      .load     (div_load),
      .step     (div_step),
      .dividend (mag_src_a),
      .divisor  (mag_src_b),
      .rem      (div_rem),
      .quo      (div_quo)
   );

   // Sign fix-up and output muxing; outputs are zero outside DONE.
   always_comb begin
      res_neg  = is_signed_op(op_q) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      rem_neg  = is_signed_op(op_q) && a_q[WIDTH-1];
      prod_fix = res_neg ? -acc_q : acc_q;
      quo_fix  = res_neg ? -div_quo : div_quo;
      rem_fix  = rem_neg ? -div_rem : div_rem;
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      whilo    = WHILO_NONE;
      whi      = '0;
      wlo      = '0;
      if (state_q == S_DONE) begin
         done  = !cancel;
         whilo = cancel ? WHILO_NONE : WHILO_BOTH;
         if (is_div_op(op_q)) begin
            if (b_q == '0) begin
               // Divide by zero: no trap, dividend passes through to HI.
               whi = a_q;
               wlo = '1;
            end else begin
               whi = rem_fix;
               wlo = quo_fix;
            end
         end else begin
            whi = prod_fix[2*WIDTH-1:WIDTH];
            wlo = prod_fix[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk, reset, start, cancel;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] whi, wlo;
   logic [1:0]  whilo;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 32;
`endif
   localparam int DIV_LAT = 32;

   muldiv_unit #(
      .WIDTH(32)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .whi    (whi),
      .wlo    (wlo),
      .whilo  (whilo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch one op and watch 45 cycles. Latency i counts negedges after the accepting edge,
   // so i=32 is the cycle N+33 DONE cycle. poke re-asserts start while busy; cancel_at pulses
   // cancel in cycle i. nbad counts cycles where whilo disagrees with done.
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit poke, input int cancel_at,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic [1:0] wl, output int npulse, output int nbad,
                         output logic busy_after);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk);
      lat = -1; hi = '0; lo = '0; wl = '0; npulse = 0; nbad = 0; busy_after = 1'b1;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         start = poke && (i < 3);
         if (poke) begin
            op = MD_MULTU; src_a = 32'd3; src_b = 32'd5;
         end else begin
            src_a = ~a; src_b = ~b;
         end
         cancel = (i == cancel_at);
         #1;
         if (done) begin
            npulse++;
            if (lat < 0) begin
               lat = i; hi = whi; lo = wlo; wl = whilo;
            end
         end
         if (whilo !== (done ? 2'b11 : 2'b00)) nbad++;
         if (i == cancel_at + 1) busy_after = busy;
      end
      start = 1'b0; cancel = 1'b0;
   endtask

   int          lat, npulse, nbad;
   logic [31:0] hi, lo;
   logic [1:0]  wl;
   logic        busy_after;

   initial begin
      reset = 1'b1; start = 1'b0; cancel = 1'b0; op = MD_MULT; src_a = '0; src_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset whilo", 64'(whilo), 64'd0);
      chk("reset whi/wlo", {whi, wlo}, 64'd0);
      reset = 1'b0;

      // 1: MULT -2 * 3
      run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, -1, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("mult latency", 64'(lat), 64'(MUL_LAT));
      chk("mult hi/lo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      chk("mult whilo", 64'(wl), 64'h3);
      chk("mult pulses", 64'(npulse), 64'd1);
      chk("mult whilo track", 64'(nbad), 64'd0);
      chk("mult idle after", 64'(busy), 64'd0);

      // 2: MULTU max * max
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, lat, hi, lo, wl, npulse, nbad,
             busy_after);
      chk("multu latency", 64'(lat), 64'(MUL_LAT));
      chk("multu hi/lo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      // MULT negative * negative
      run_op(MD_MULT, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 1'b0, -1, lat, hi, lo, wl, npulse, nbad,
             busy_after);
      chk("mult neg*neg hi/lo", {hi, lo}, 64'd21);

      // 3: DIV -7 / 2
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("div latency", 64'(lat), 64'(DIV_LAT));
      chk("div hi/lo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("div whilo", 64'(wl), 64'h3);
      chk("div pulses", 64'(npulse), 64'd1);

      // DIVU 100 / 7
      run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, -1, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("divu hi/lo", {hi, lo}, {32'd2, 32'd14});

      // DIVU 7 / 0 and DIV -7 / 0
      run_op(MD_DIVU, 32'd7, 32'd0, 1'b0, -1, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("divu by zero latency", 64'(lat), 64'(DIV_LAT));
      chk("divu by zero hi/lo", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0, -1, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("div by zero hi/lo", {hi, lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});

      // 4: overflow divide, with a second start while busy
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, lat, hi, lo, wl, npulse, nbad,
             busy_after);
      chk("div ovf latency", 64'(lat), 64'(DIV_LAT));
      chk("div ovf hi/lo", {hi, lo}, {32'd0, 32'h8000_0000});
      chk("restart ignored pulses", 64'(npulse), 64'd1);
      chk("restart ignored idle", 64'(busy), 64'd0);

      // 5: cancel during cycle N+10 of a DIV
      run_op(MD_DIV, 32'd1000, 32'd3, 1'b0, 9, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("cancel busy next", 64'(busy_after), 64'd0);
      chk("cancel no done", 64'(npulse), 64'd0);
      chk("cancel whilo", 64'(nbad), 64'd0);

      // cancel in the DONE cycle suppresses the write
      run_op(MD_DIVU, 32'd100, 32'd7, 1'b0, 32, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("cancel in done pulses", 64'(npulse), 64'd0);
      chk("cancel in done whilo", 64'(nbad), 64'd0);
      chk("cancel in done idle", 64'(busy_after), 64'd0);

      // cancel and start together
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = MD_DIVU; src_a = 32'd9; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      #1;
      chk("cancel+start busy", 64'(busy), 64'd0);
      @(negedge clk);
      chk("cancel+start stays idle", 64'(busy), 64'd0);

      // 6: reset mid-MUL (or mid-DIV to get a long-running op in the fast build)
      @(negedge clk);
      start = 1'b1; op = MD_DIV; src_a = 32'd77; src_b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre-reset busy", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      chk("reset mid-op busy", 64'(busy), 64'd0);
      chk("reset mid-op done/whilo", {61'd0, done, whilo}, 64'd0);
      chk("reset mid-op whi/wlo", {whi, wlo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      @(negedge clk);
      start = 1'b1; op = MD_MULT; src_a = 32'd5; src_b = 32'd6;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset mid-mul outputs", {29'd0, busy, done, whilo, whi}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // recovery, and the fast-path check case
      run_op(MD_MULTU, 32'd3, 32'd5, 1'b0, -1, lat, hi, lo, wl, npulse, nbad, busy_after);
      chk("multu 3*5 latency", 64'(lat), 64'(MUL_LAT));
      chk("multu 3*5 hi/lo", {hi, lo}, 64'd15);
      chk("multu 3*5 pulses", 64'(npulse), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
